// File: rtl/id_ex_pkg.sv
// Shared types and default widths for the ID/EX operand stage.
// fwd_src_t names the source picked for one forwarded operand.
package id_ex_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_1,
        FWD_2,
        FWD_ZERO
    } fwd_src_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_sel.sv
// Combinational operand forward select for one source register.
// r0 always reads zero; the nearer downstream stage (fw1) beats fw2.
module fwd_sel
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic [REG_W-1:0]  src_reg,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              fw1_we,
    input  logic [REG_W-1:0]  fw1_reg,
    input  logic [DATA_W-1:0] fw1_data,
    input  logic              fw2_we,
    input  logic [REG_W-1:0]  fw2_reg,
    input  logic [DATA_W-1:0] fw2_data,
    output logic [DATA_W-1:0] fwd_data,
    output fwd_src_t          fwd_src
);

    always_comb begin
        fwd_src = FWD_RF;
        if (src_reg == '0) begin
            fwd_src = FWD_ZERO;
        end else if (fw1_we && (fw1_reg == src_reg)) begin
            fwd_src = FWD_1;
        end else if (fw2_we && (fw2_reg == src_reg)) begin
            fwd_src = FWD_2;
        end
    end

    always_comb begin
        fwd_data = rf_data;
        case (fwd_src)
            FWD_ZERO: fwd_data = '0;
            FWD_1:    fwd_data = fw1_data;
            FWD_2:    fwd_data = fw2_data;
            default:  fwd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and a
// saturating stall counter; forward sources are exported for debug.
module id_ex_operand_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    input  logic [DATA_W-1:0] ext,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              fw1_RegWrite,
    input  logic              fw1_pending,
    input  logic [REG_W-1:0]  fw1_reg,
    input  logic [DATA_W-1:0] fw1_data,
    input  logic              fw2_RegWrite,
    input  logic [REG_W-1:0]  fw2_reg,
    input  logic [DATA_W-1:0] fw2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_W-1:0]  DstReg,
    output logic              MemtoReg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic [CNT_W-1:0]  stall_cnt,
    output fwd_src_t          dbg_fwd_a,
    output fwd_src_t          dbg_fwd_b
);

    logic [DATA_W-1:0] fa, fb;

    fwd_sel #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_a (
        .src_reg (rs),        .rf_data (rf_out1),
        .fw1_we  (fw1_RegWrite), .fw1_reg (fw1_reg), .fw1_data (fw1_data),
        .fw2_we  (fw2_RegWrite), .fw2_reg (fw2_reg), .fw2_data (fw2_data),
        .fwd_data(fa),        .fwd_src (dbg_fwd_a)
    );

    fwd_sel #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_b (
        .src_reg (rt),        .rf_data (rf_out2),
        .fw1_we  (fw1_RegWrite), .fw1_reg (fw1_reg), .fw1_data (fw1_data),
        .fw2_we  (fw2_RegWrite), .fw2_reg (fw2_reg), .fw2_data (fw2_data),
        .fwd_data(fb),        .fwd_src (dbg_fwd_b)
    );

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, store_data_q, store_data_d;
    logic [REG_W-1:0]  dst_reg_q, dst_reg_d;
    logic              mem_to_reg_q, mem_to_reg_d, mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d, reg_write_q, reg_write_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic rt_used, hazard, adv;

    // Handshakes: a word moves on a side when valid && ready at the rising
    // edge; flush always drains the input side and squashes the stage.
    always_comb begin
        rt_used  = !ALUSrc || MemWrite_in;
        hazard   = in_valid && fw1_pending && fw1_RegWrite && (fw1_reg != '0) &&
                   ((fw1_reg == rs) || (rt_used && (fw1_reg == rt)));
        adv      = out_ready || !out_valid_q;
        in_ready = flush || (adv && !hazard);
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        store_data_d = store_data_q;
        dst_reg_d    = dst_reg_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (adv && hazard) begin
            out_valid_d = 1'b0;
        end else if (adv && in_valid) begin
            out_valid_d  = 1'b1;
            op_a_d       = fa;
            op_b_d       = ALUSrc ? ext : fb;
            store_data_d = fb;
            dst_reg_d    = RegDst ? rd : rt;
            mem_to_reg_d = MemtoReg_in;
            mem_read_d   = MemRead_in;
            mem_write_d  = MemWrite_in;
            reg_write_d  = RegWrite_in;
        end else if (adv) begin
            out_valid_d = 1'b0;
        end
    end

    // Counts stalled decode cycles, including those hidden behind backpressure.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            store_data_q <= '0;
            dst_reg_q    <= '0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            store_data_q <= store_data_d;
            dst_reg_q    <= dst_reg_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Side-effecting controls are masked so a bubble can never write.
    assign out_valid  = out_valid_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign store_data = store_data_q;
    assign DstReg     = dst_reg_q;
    assign MemtoReg   = mem_to_reg_q;
    assign MemRead    = mem_read_q && out_valid_q;
    assign MemWrite   = mem_write_q && out_valid_q;
    assign RegWrite   = reg_write_q && out_valid_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Parametrised successor to the single-cycle datapath selectors: resolves register destination, ALU operand B and store data with operand forwarding, then registers the result as the ID/EX pipeline stage. Detects load-use hazards and stalls ID with a valid/ready handshake. Sits between the decode/regfile read and the ALU in the pipelined core, and keeps a saturating stall counter for performance monitoring.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register-address width
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid / in_ready  in / out  1  ID-side handshake
- rs, rt, rd  in  REG_W  instr[25:21], [20:16], [15:11]
- rf_out1, rf_out2  in  DATA_W  regfile reads for rs, rt
- ext  in  DATA_W  extended immediate
- RegDst, ALUSrc, MemtoReg_in, MemRead_in, MemWrite_in, RegWrite_in  in  1  decode controls
- fw1_RegWrite, fw1_pending  in  1  nearest downstream stage writes; its data not yet available (load)
- fw1_reg  in  REG_W; fw1_data  in  DATA_W
- fw2_RegWrite  in  1; fw2_reg  in  REG_W; fw2_data  in  DATA_W  second downstream stage
- flush  in  1  synchronous squash
- out_valid / out_ready  out / in  1  EX-side handshake
- op_a, op_b, store_data  out  DATA_W  registered operands
- DstReg  out  REG_W  registered destination
- MemtoReg, MemRead, MemWrite, RegWrite  out  1  registered controls
- stall_cnt  out  CNT_W  saturating load-use stall count

## Operation
- Forward select, per source register s with regfile value v: s==0 -> 0; else fw1_RegWrite && fw1_reg==s -> fw1_data; else fw2_RegWrite && fw2_reg==s -> fw2_data; else v. fw1 beats fw2.
- fa = fwd(rs, rf_out1); fb = fwd(rt, rf_out2).
- op_a = fa; op_b = ALUSrc ? ext : fb; store_data = fb; DstReg = RegDst ? rd : rt.
- rt is "used" when ALUSrc==0 or MemWrite_in==1; rs is always used.
- hazard = in_valid && fw1_pending && fw1_RegWrite && fw1_reg!=0 && (fw1_reg==rs || (rt used && fw1_reg==rt)).
- adv = out_ready || !out_valid.
- in_ready = flush || (adv && !hazard).
- Register update, priority order:
  - flush: out_valid<=0; input discarded.
  - adv && hazard: out_valid<=0 (bubble); input held.
  - adv && in_valid: load all outputs, out_valid<=1.
  - adv && !in_valid: out_valid<=0.
  - else hold every output.
- stall_cnt increments each cycle hazard && !flush; saturates at all-ones.
- When out_valid==0, the control outputs MemRead, MemWrite and RegWrite are forced to 0, so bubbles have no side effects.

## Timing
- Latency 1 cycle, input accept to out_valid.
- in_ready and hazard are combinational from inputs; no comb path from out_ready to op_*.
- Reset (async assert; release taken at clk edge): every output 0, out_valid 0, stall_cnt 0.
- Hazard with out_ready low: output holds; bubble is inserted only once adv.
- flush and hazard in the same cycle: flush wins, no stall count.
- Reset mid-stall: state cleared; in_ready re-evaluated combinationally.
- Throughput: one instruction per cycle absent hazard/backpressure.

## Structure
- Package id_ex_pkg: fwd_src_t enum {FWD_RF, FWD_1, FWD_2, FWD_ZERO}; default widths.
- Sub-module fwd_sel (combinational forward select, also outputs fwd_src_t for debug), instantiated twice (rs, rt).
- Stage register, hazard logic and counter live in the top.

## Test plan
- No hazards: rs=1 (rf_out1=5), rt=2 (rf_out2=7), ALUSrc=0, RegDst=1, rd=3 -> next cycle op_a=5, op_b=7, DstReg=3, out_valid=1.
- Priority: rs=4, fw1 writes r4=0xAA, fw2 writes r4=0xBB -> op_a=0xAA. With fw1_RegWrite=0 -> op_a=0xBB. With rs=0 and both writing r0 -> op_a=0.
- Load-use: fw1_pending=1, fw1_reg=2=rt, ALUSrc=0 -> in_ready=0, bubble out (RegWrite=0), stall_cnt=1. Drop pending with fw1_data=9 -> op_b=9. Same case with ALUSrc=1 and MemWrite_in=0 -> no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; first accepted after out_ready=1.
- flush with hazard active -> out_valid=0 next cycle, in_ready=1, stall_cnt unchanged.
- CNT_W=4: 20 hazard cycles -> stall_cnt=15. Async rst pulse mid-stall -> all outputs 0 immediately.
